// File: rtl/dmem_lsu.sv
// Load/store unit between the core data-move path and the dual-port data RAM.
// In-order request FIFO, one store per cycle, blocking loads with a valid/ready response.
module dmem_lsu #(
    parameter int DW       = 24,
    parameter int AW       = 24,
    parameter int MEM_SIZE = 2048,
    parameter int QDEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [AW-1:0] dwaddr,
    output logic [DW-1:0] dwdata,
    output logic          dwen,
    output logic [AW-1:0] draddr,
    input  logic [DW-1:0] drdata
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL      = CW'(QDEPTH);
    localparam logic [AW-1:0] MEM_LIMIT = AW'(MEM_SIZE);

    typedef enum logic [1:0] {IDLE, LWAIT, RHOLD} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    state_t        state_q, state_d;
    req_t          fifo_q [QDEPTH];
    req_t          fifo_d [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;

    logic push, pop, head_vld, head_in_range;
    req_t head;

    assign req_ready     = (count_q != FULL);
    assign push          = req_valid && req_ready;
    assign head_vld      = (count_q != '0);
    assign head          = fifo_q[rd_ptr_q];
    assign head_in_range = (head.addr < MEM_LIMIT);

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        dwen        = 1'b0;
        dwaddr      = '0;
        dwdata      = '0;
        draddr      = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (head_vld) begin
                    pop = 1'b1;
                    if (head.we) begin
                        // Out-of-range stores are consumed without touching the RAM.
                        if (head_in_range) begin
                            dwen   = 1'b1;
                            dwaddr = head.addr;
                            dwdata = head.wdata;
                        end
                    end else if (head_in_range) begin
                        draddr  = head.addr;
                        state_d = LWAIT;
                    end else begin
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RHOLD;
                    end
                end
            end
            LWAIT: begin
                rsp_data_d  = drdata;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = RHOLD;
            end
            RHOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = '{we: req_we, addr: req_addr, wdata: req_wdata};
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Entry storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end
endmodule
